// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready handshake with programmable wait states
// and byte/halfword RMW stores. Optional error path: define MEM_MISALIGN_EXC_EN.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
`ifdef MEM_MISALIGN_EXC_EN
    output logic        busy,
    output logic        err
`else
    output logic        busy
`endif
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MERGE, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic [IW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [IW-1:0] idx;
    logic [31:0]   cur_word, rd_ext, merged, mem_wdata;
    logic          mem_we, is_word;
    logic          unused_addr_hi;

    // Upper address bits beyond the array wrap silently.
    assign unused_addr_hi = ^addr[31:IW+2];

    assign idx      = addr_q[IW+1:2];
    assign cur_word = mem[idx];
    // size 00 and 11 both behave as word accesses on the non-error path
    assign is_word  = (size_q[1] == size_q[0]);

    always_comb begin
        rd_ext = cur_word;
        case (size_q)
            2'b01:   rd_ext = {16'h0, addr_q[1] ? cur_word[31:16] : cur_word[15:0]};
            2'b10:   rd_ext = {24'h0, cur_word[{addr_q[1:0], 3'b000} +: 8]};
            default: rd_ext = cur_word;
        endcase
    end

    always_comb begin
        merged = cur_word;
        if (size_q == 2'b10)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

`ifdef MEM_MISALIGN_EXC_EN
    logic err_q, err_d;
    logic misaligned;
    assign misaligned = (size == 2'b11) ||
                        (size == 2'b00 && addr[1:0] != 2'b00) ||
                        (size == 2'b01 && addr[0]);
    assign err = err_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
`ifdef MEM_MISALIGN_EXC_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    addr_d  = addr[IW+1:0];
                    wdata_d = wdata;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    state_d = S_WAIT;
`ifdef MEM_MISALIGN_EXC_EN
                    if (misaligned) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!we_q) begin
                    rdata_d = rd_ext;
                    state_d = S_RESP;
                end else if (is_word) begin
                    mem_we  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_MERGE;
                end
            end
            S_MERGE: begin
                mem_we    = 1'b1;
                mem_wdata = merged;
                state_d   = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
`ifdef MEM_MISALIGN_EXC_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_MISALIGN_EXC_EN
            err_q   <= err_d;
`endif
        end
    end

    // No reset on the array; a write due on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !reset)
            mem[idx] <= mem_wdata;
    end

    assign rdata = rdata_q;
    assign ready = (state_q == S_RESP);
    assign busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one DUT with WAIT_CYCLES=1, one with WAIT_CYCLES=3.
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_req = 0, a_we = 0;
    logic [1:0]  a_size = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
    logic        a_ready, a_busy, a_err;
    logic        b_req = 0, b_we = 0;
    logic [1:0]  b_size = 0;
    logic [31:0] b_addr = 0, b_wdata = 0, b_rdata;
    logic        b_ready, b_busy;

    int tests = 0;
    int fails = 0;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .req(a_req), .we(a_we), .size(a_size),
        .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready),
`ifdef MEM_MISALIGN_EXC_EN
        .busy(a_busy), .err(a_err)
`else
        .busy(a_busy)
`endif
    );

`ifdef MEM_MISALIGN_EXC_EN
    logic b_err;
`else
    assign a_err = 1'b0;
`endif

    mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .we(b_we), .size(b_size),
        .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready),
`ifdef MEM_MISALIGN_EXC_EN
        .busy(b_busy), .err(b_err)
`else
        .busy(b_busy)
`endif
    );

    // Cycle 0 is the cycle req is high; lat is the cycle in which ready was seen.
    task automatic acc_a(input logic w, input logic [1:0] sz, input logic [31:0] ad, wd,
                         output int lat, output logic [31:0] rd, output logic e);
        a_we = w; a_size = sz; a_addr = ad; a_wdata = wd; a_req = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1; a_req = 1'b0; lat++;
        end while (!a_ready && lat < 20);
        rd = a_rdata; e = a_err;
        @(posedge clk); #1;
    endtask

    task automatic acc_b(input logic w, input logic [31:0] ad, wd,
                         output int lat, output logic [31:0] rd);
        b_we = w; b_size = 2'b00; b_addr = ad; b_wdata = wd; b_req = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1; b_req = 1'b0; lat++;
        end while (!b_ready && lat < 20);
        rd = b_rdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tests++; if ({a_ready, a_busy, a_err} !== 3'b000) begin fails++;
            $display("FAIL reset_flags_a: got %b want 000", {a_ready, a_busy, a_err}); end
        tests++; if (a_rdata !== 32'h0) begin fails++;
            $display("FAIL reset_rdata_a: got %h want 00000000", a_rdata); end
        tests++; if ({b_ready, b_busy, b_rdata} !== 34'h0) begin fails++;
            $display("FAIL reset_b: got %b %b %h want 0 0 0", b_ready, b_busy, b_rdata); end
    endtask

    task automatic test_word;
        int lat; logic [31:0] rd; logic e;
        acc_a(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, lat, rd, e);
        tests++; if (lat !== 2) begin fails++; $display("FAIL word_wr_lat: got %0d want 2", lat); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL word_wr_rdata: got %h want 0", rd); end
        acc_a(1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
        tests++; if (lat !== 2) begin fails++; $display("FAIL word_rd_lat: got %0d want 2", lat); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++;
            $display("FAIL word_rd: got %h want deadbeef", rd); end
    endtask

    task automatic test_subword_store;
        int lat; logic [31:0] rd; logic e;
        acc_a(1'b1, 2'b10, 32'h12, 32'h000000AA, lat, rd, e);
        tests++; if (lat !== 3) begin fails++; $display("FAIL byte_wr_lat: got %0d want 3", lat); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++;
            $display("FAIL byte_wr_keeps_rdata: got %h want deadbeef", rd); end
        acc_a(1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'hDEAABEEF) begin fails++;
            $display("FAIL byte_rmw: got %h want deaabeef", rd); end
        acc_a(1'b1, 2'b00, 32'h14, 32'h0, lat, rd, e);
        acc_a(1'b1, 2'b01, 32'h16, 32'hFFFF1234, lat, rd, e);
        tests++; if (lat !== 3) begin fails++; $display("FAIL half_wr_lat: got %0d want 3", lat); end
        acc_a(1'b0, 2'b00, 32'h14, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h12340000) begin fails++;
            $display("FAIL half_rmw: got %h want 12340000", rd); end
    endtask

    task automatic test_subword_read;
        int lat; logic [31:0] rd; logic e;
        acc_a(1'b0, 2'b01, 32'h12, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h0000DEAA) begin fails++;
            $display("FAIL half_rd_hi: got %h want 0000deaa", rd); end
        acc_a(1'b0, 2'b01, 32'h10, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h0000BEEF) begin fails++;
            $display("FAIL half_rd_lo: got %h want 0000beef", rd); end
        acc_a(1'b0, 2'b10, 32'h13, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h000000DE) begin fails++;
            $display("FAIL byte_rd3: got %h want 000000de", rd); end
        acc_a(1'b0, 2'b10, 32'h11, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h000000BE) begin fails++;
            $display("FAIL byte_rd1: got %h want 000000be", rd); end
    endtask

    task automatic test_wait_states;
        int lat; logic [31:0] rd;
        acc_b(1'b1, 32'h0, 32'h5A5A5A5A, lat, rd);
        tests++; if (lat !== 4) begin fails++; $display("FAIL wait_wr_lat: got %0d want 4", lat); end
        b_we = 1'b0; b_addr = 32'h0; b_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin b_we = 1'b1; b_wdata = 32'h0BAD0BAD; end
            tests++; if (b_busy !== 1'b1) begin fails++;
                $display("FAIL wait_busy c%0d: got %b want 1", c, b_busy); end
            tests++; if (b_ready !== (c == 4)) begin fails++;
                $display("FAIL wait_ready c%0d: got %b want %b", c, b_ready, c == 4); end
        end
        tests++; if (b_rdata !== 32'h5A5A5A5A) begin fails++;
            $display("FAIL wait_rd: got %h want 5a5a5a5a", b_rdata); end
        b_req = 1'b0;
        @(posedge clk); #1;
        tests++; if ({b_busy, b_ready} !== 2'b00) begin fails++;
            $display("FAIL wait_not_queued: got %b want 00", {b_busy, b_ready}); end
        acc_b(1'b0, 32'h0, 32'h0, lat, rd);
        tests++; if (rd !== 32'h5A5A5A5A) begin fails++;
            $display("FAIL wait_ignored_wr: got %h want 5a5a5a5a", rd); end
    endtask

    task automatic test_reset_mid_write;
        int lat; logic [31:0] rd; logic e; int seen;
        acc_a(1'b1, 2'b00, 32'h20, 32'h11111111, lat, rd, e);
        a_we = 1'b1; a_size = 2'b00; a_addr = 32'h20; a_wdata = 32'h22222222; a_req = 1'b1;
        @(posedge clk); #1; a_req = 1'b0; reset = 1'b1;
        tests++; if (a_busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy: got %b want 1", a_busy); end
        @(posedge clk); #1; reset = 1'b0;
        tests++; if ({a_busy, a_ready, a_rdata} !== 34'h0) begin fails++;
            $display("FAIL rst_mid_state: got %b %b %h want 0 0 0", a_busy, a_ready, a_rdata); end
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (a_ready) seen++; end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rst_mid_ready: got %0d pulses want 0", seen); end
        acc_a(1'b0, 2'b00, 32'h20, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h11111111) begin fails++;
            $display("FAIL rst_mid_dropped: got %h want 11111111", rd); end
    endtask

    task automatic test_misalign;
        int lat; logic [31:0] rd; logic e;
        acc_a(1'b1, 2'b00, 32'h22, 32'hCAFEF00D, lat, rd, e);
`ifdef MEM_MISALIGN_EXC_EN
        tests++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin fails++;
            $display("FAIL mis_wr: got lat %0d err %b rdata %h want 1 1 0", lat, e, rd); end
        acc_a(1'b0, 2'b00, 32'h20, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h11111111 || e !== 1'b0) begin fails++;
            $display("FAIL mis_untouched: got %h err %b want 11111111 0", rd, e); end
        acc_a(1'b0, 2'b11, 32'h20, 32'h0, lat, rd, e);
        tests++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin fails++;
            $display("FAIL mis_size11: got lat %0d err %b rdata %h want 1 1 0", lat, e, rd); end
        acc_a(1'b0, 2'b01, 32'h13, 32'h0, lat, rd, e);
        tests++; if (lat !== 1 || e !== 1'b1) begin fails++;
            $display("FAIL mis_half: got lat %0d err %b want 1 1", lat, e); end
`else
        tests++; if (lat !== 2) begin fails++; $display("FAIL mask_wr_lat: got %0d want 2", lat); end
        acc_a(1'b0, 2'b00, 32'h20, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'hCAFEF00D) begin fails++;
            $display("FAIL mask_wr: got %h want cafef00d", rd); end
        acc_a(1'b0, 2'b11, 32'h21, 32'h0, lat, rd, e);
        tests++; if (lat !== 2 || rd !== 32'hCAFEF00D) begin fails++;
            $display("FAIL mask_size11: got lat %0d rdata %h want 2 cafef00d", lat, rd); end
        acc_a(1'b0, 2'b01, 32'h13, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h0000DEAA) begin fails++;
            $display("FAIL mask_half: got %h want 0000deaa", rd); end
`endif
    endtask

    initial begin
        test_reset;
        test_word;
        test_subword_store;
        test_subword_read;
        test_wait_states;
        test_reset_mid_write;
        test_misalign;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
